// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed BCD display.
// Contents:
//   NUM_DIGITS  - number of BCD digits / display positions
//   bcd_digit_t - one 4-bit BCD digit
//   SEG_*       - active-low segment codes, [7:1]=a..g, [0]=dp
//   bcd_inc     - ripple BCD increment of the packed count, returns {carry, next}
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Carry out of the top digit means the count rolled 9999 -> 0000.
  function automatic logic [4*NUM_DIGITS:0] bcd_inc(input logic [4*NUM_DIGITS-1:0] v);
    logic [4*NUM_DIGITS-1:0] r;
    logic                    c;
    bcd_digit_t              d;
    r = '0;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[i*4 +: 4];
      if (c) begin
        if (d == 4'd9) begin
          d = 4'd0;
          c = 1'b1;
        end else begin
          d = d + 4'd1;
          c = 1'b0;
        end
      end
      r[i*4 +: 4] = d;
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Ports:
//   i_digit - BCD digit to show
//   i_blank - 1 forces all segments off
//   o_seg   - active-low segments, [7:1]=a..g, [0]=dp (dp always off)
module seg7_decode
  import disp_pkg::*;
(
  input  bcd_digit_t  i_digit,
  input  logic        i_blank,
  output logic [7:0]  o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/tick_bcd_counter_display.sv
// 4-digit BCD event counter driven by a one-cycle tick, shown on a
// multiplexed common-anode 7-segment display.
// Parameters:
//   SCAN_DIV - clk cycles per digit scan slot (>= 2)
//   BLANK_LZ - 1 blanks leading zeros on digits 3..1
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   update    - one-cycle tick; increments the count
//   hold      - freezes the count, drops ticks
//   clr       - synchronous clear of the count (highest priority)
//   wrap      - one-cycle pulse on 9999 -> 0000 rollover
//   count_bcd - packed BCD count, digit 3 in [15:12]
//   led_en    - active-low digit enables
//   led_seg   - active-low segments, [7:1]=a..g, [0]=dp
module tick_bcd_counter_display
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        update,
  input  logic        hold,
  input  logic        clr,
  output logic        wrap,
  output logic [15:0] count_bcd,
  output logic [3:0]  led_en,
  output logic [7:0]  led_seg
);

  localparam int              CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  logic [15:0]      r_count;
  logic             r_wrap;
  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_led_en;
  logic [7:0]       r_led_seg;

  logic [16:0]      w_inc;
  bcd_digit_t       w_dig [NUM_DIGITS];
  logic [3:0]       w_zero;
  bcd_digit_t       w_digit;
  logic             w_blank;
  logic [7:0]       w_seg;

  assign w_inc = bcd_inc(r_count);

  // Count: clr > hold > update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 16'h0000;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_count <= 16'h0000;
      r_wrap  <= 1'b0;
    end else if (hold) begin
      r_wrap  <= 1'b0;
    end else if (update) begin
      r_count <= w_inc[15:0];
      r_wrap  <= w_inc[16];
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  // Scan timer free-runs regardless of hold/clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign w_dig[g]  = r_count[g*4 +: 4];
    assign w_zero[g] = (w_dig[g] == 4'd0);
  end

  // A digit is a leading zero only if it and every digit above it are zero;
  // digit 0 always shows so that a zero count reads "   0".
  always_comb begin
    w_digit = w_dig[0];
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin w_digit = w_dig[0]; w_blank = 1'b0;         end
      2'd1: begin w_digit = w_dig[1]; w_blank = &w_zero[3:1]; end
      2'd2: begin w_digit = w_dig[2]; w_blank = &w_zero[3:2]; end
      2'd3: begin w_digit = w_dig[3]; w_blank = w_zero[3];    end
      default: begin w_digit = w_dig[0]; w_blank = 1'b0;      end
    endcase
    w_blank = w_blank && BLANK_LZ;
  end

  seg7_decode u_seg7_decode (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  // Registered display drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_en  <= 4'b1111;
      r_led_seg <= SEG_BLANK;
    end else begin
      r_led_en  <= ~(4'b0001 << r_idx);
      r_led_seg <= w_seg;
    end
  end

  assign wrap      = r_wrap;
  assign count_bcd = r_count;
  assign led_en    = r_led_en;
  assign led_seg   = r_led_seg;

endmodule

// File: tb/tb_tick_bcd_counter_display.sv
module tb_tick_bcd_counter_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        update;
  logic        hold;
  logic        clr;
  logic        wrap;
  logic [15:0] count_bcd;
  logic [3:0]  led_en;
  logic [7:0]  led_seg;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  tick_bcd_counter_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .update    (update),
    .hold      (hold),
    .clr       (clr),
    .wrap      (wrap),
    .count_bcd (count_bcd),
    .led_en    (led_en),
    .led_seg   (led_seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c;
    logic        h;
    logic        u;
    logic [15:0] cnt;
    logic        w;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply(input logic c, input logic h, input logic u);
    clr = c; hold = h; update = u;
    tick();
    clr = 1'b0; hold = 1'b0; update = 1'b0;
  endtask

  // Slot shown after the cyc-th edge since reset release
  function automatic int slot_of(input int n);
    return ((n - 1) / SD) % 4;
  endfunction

  task automatic wait_slot(input int idx, input logic [7:0] exp_seg, input string name);
    logic [3:0] en;
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (slot_of(cyc) != idx && n < 20);
    en = ~(4'b0001 << idx);
    chk({name, "_en"}, {28'd0, led_en}, {28'd0, en});
    chk({name, "_seg"}, {24'd0, led_seg}, {24'd0, exp_seg});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] en;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};

    rst_n = 1'b0; clr = 1'b0; hold = 1'b0; update = 1'b0;
    #12;
    chk("rst_count", {16'd0, count_bcd}, 32'h0000);
    chk("rst_wrap",  {31'd0, wrap},      32'd0);
    chk("rst_en",    {28'd0, led_en},    32'hF);
    chk("rst_seg",   {24'd0, led_seg},   32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    tick();
    chk("idle_count", {16'd0, count_bcd}, 32'h0000);
    chk("idle_wrap",  {31'd0, wrap},      32'd0);
    chk("idle_en",    {28'd0, led_en},    32'hE);
    chk("idle_seg",   {24'd0, led_seg},   32'h03);

    // Priority table
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].c, vecs[i].h, vecs[i].u);
      chk($sformatf("vec%0d_count", i), {16'd0, count_bcd}, {16'd0, vecs[i].cnt});
      chk($sformatf("vec%0d_wrap", i),  {31'd0, wrap},      {31'd0, vecs[i].w});
    end

    // 37 spaced pulses
    for (int i = 0; i < 37; i++) begin
      apply(1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 1'b0);
    end
    chk("c37_count", {16'd0, count_bcd}, 32'h0037);
    wait_slot(0, 8'h1F, "c37_d0");
    wait_slot(1, 8'h0D, "c37_d1");
    wait_slot(2, 8'hFF, "c37_d2");
    wait_slot(3, 8'hFF, "c37_d3");

    // Back-to-back up to 9998, then rollover
    for (int i = 0; i < 9998 - 37; i++) apply(1'b0, 1'b0, 1'b1);
    chk("c9998_count", {16'd0, count_bcd}, 32'h9998);
    apply(1'b0, 1'b0, 1'b1);
    chk("c9999_count", {16'd0, count_bcd}, 32'h9999);
    chk("c9999_wrap",  {31'd0, wrap},      32'd0);
    wait_slot(3, 8'h09, "c9999_d3");
    apply(1'b0, 1'b0, 1'b1);
    chk("roll_count", {16'd0, count_bcd}, 32'h0000);
    chk("roll_wrap",  {31'd0, wrap},      32'd1);
    apply(1'b0, 1'b0, 1'b0);
    chk("roll_wrap_end", {31'd0, wrap},   32'd0);
    wait_slot(0, 8'h03, "c0_d0");
    wait_slot(1, 8'hFF, "c0_d1");
    wait_slot(2, 8'hFF, "c0_d2");
    wait_slot(3, 8'hFF, "c0_d3");

    // Interior zero not blanked, then clr+update at 0123, then hold
    for (int i = 0; i < 100; i++) apply(1'b0, 1'b0, 1'b1);
    wait_slot(1, 8'h03, "c100_d1");
    wait_slot(2, 8'h9F, "c100_d2");
    for (int i = 0; i < 23; i++) apply(1'b0, 1'b0, 1'b1);
    chk("c123_count", {16'd0, count_bcd}, 32'h0123);
    apply(1'b1, 1'b0, 1'b1);
    chk("clrupd_count", {16'd0, count_bcd}, 32'h0000);
    chk("clrupd_wrap",  {31'd0, wrap},      32'd0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, 1'b1);
      chk($sformatf("hold%0d_count", i), {16'd0, count_bcd}, 32'h0000);
    end

    // Scan sequence over 16 cycles with hold/clr activity
    begin
      int n;
      n = 0;
      while (((cyc - 1) % 16) != 15 && n < 32) begin
        tick();
        n++;
      end
    end
    for (int j = 0; j < 16; j++) begin
      clr = (j == 5) || (j == 11);
      hold = j[0];
      update = j[1];
      tick();
      en = ~(4'b0001 << (j / 4));
      chk($sformatf("scan%0d_en", j), {28'd0, led_en}, {28'd0, en});
      chk($sformatf("scan%0d_onehot", j), $countones(~led_en), 32'd1);
    end
    clr = 1'b0; hold = 1'b0; update = 1'b0;

    // Count to 0512, then asynchronous reset mid-scan
    apply(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 512; i++) apply(1'b0, 1'b0, 1'b1);
    chk("c512_count", {16'd0, count_bcd}, 32'h0512);
    wait_slot(0, 8'h25, "c512_d0");
    wait_slot(1, 8'h9F, "c512_d1");
    wait_slot(2, 8'h49, "c512_d2");
    wait_slot(3, 8'hFF, "c512_d3");
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", {16'd0, count_bcd}, 32'h0000);
    chk("arst_wrap",  {31'd0, wrap},      32'd0);
    chk("arst_en",    {28'd0, led_en},    32'hF);
    chk("arst_seg",   {24'd0, led_seg},   32'hFF);
    @(posedge clk);
    #2;
    chk("arst_hold_en", {28'd0, led_en}, 32'hF);
    rst_n = 1'b1;
    cyc = 0;
    tick();
    chk("rel_en",    {28'd0, led_en},    32'hE);
    chk("rel_seg",   {24'd0, led_seg},   32'h03);
    chk("rel_count", {16'd0, count_bcd}, 32'h0000);
    apply(1'b0, 1'b0, 1'b1);
    chk("rel_upd_count", {16'd0, count_bcd}, 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
